// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one fixed-latency read memory between instruction fetch (I)
// and load data (D). Each response is routed back to the port that was granted.
module imem_dmem_arbiter #(
  parameter int AW         = 4,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rr_mode,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          fetch_stall
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic               last_d;
  logic [SW-1:0]      starve_cnt;
  logic [MEM_LAT-1:0] tag_v;
  logic [MEM_LAT-1:0] tag_d;
  logic               i_win;

  always_comb begin
    i_win = i_req;
    if (i_req && d_req) begin
      if (rr_mode) i_win = last_d;
      else         i_win = (starve_cnt == SW'(STARVE_MAX));
    end
  end

  assign i_gnt       = i_win;
  assign d_gnt       = d_req & ~i_win;
  assign mem_en      = i_gnt | d_gnt;
  assign mem_addr    = i_gnt ? i_addr : (d_gnt ? d_addr : '0);
  assign fetch_stall = i_req & ~i_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d     <= 1'b1;
      starve_cnt <= '0;
    end else begin
      if (mem_en) last_d <= d_gnt;
      if (!i_req || i_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // The tag shift register covers the memory latency; the rvalid/rdata
  // registers form the final stage, giving MEM_LAT+1 cycles grant-to-rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_d <= '0;
    end else begin
      tag_v[0] <= mem_en;
      tag_d[0] <= d_gnt;
      for (int k = 1; k < MEM_LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_d[k] <= tag_d[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= tag_v[MEM_LAT-1] & ~tag_d[MEM_LAT-1];
      d_rvalid <= tag_v[MEM_LAT-1] &  tag_d[MEM_LAT-1];
      if (tag_v[MEM_LAT-1] && !tag_d[MEM_LAT-1]) i_rdata <= mem_rdata;
      if (tag_v[MEM_LAT-1] &&  tag_d[MEM_LAT-1]) d_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=2) share
// stimulus; grants and responses are checked against a rule-level model.
module tb_imem_dmem_arbiter;

  localparam int SMAX = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rr_mode = 1'b0;
  logic       i_req = 1'b0;
  logic       d_req = 1'b0;
  logic [3:0] i_addr = '0;
  logic [3:0] d_addr = '0;

  logic [1:0]  i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, fetch_stall;
  logic [31:0] i_rdata [2];
  logic [31:0] d_rdata [2];
  logic [3:0]  mem_addr [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] mem [16];
  logic [31:0] p1_a, p2_a, p2_b;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.AW(4), .DW(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]), .fetch_stall(fetch_stall[0])
  );

  imem_dmem_arbiter #(.AW(4), .DW(32), .MEM_LAT(2), .STARVE_MAX(SMAX)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]), .fetch_stall(fetch_stall[1])
  );

  // Fixed-latency memories: data appears MEM_LAT cycles after the address.
  always @(posedge clk) begin
    p1_a <= mem[mem_addr[0]];
    p2_a <= mem[mem_addr[1]];
    p2_b <= p2_a;
  end
  assign mem_rdata[0] = p1_a;
  assign mem_rdata[1] = p2_b;

  typedef struct {
    int          due;
    bit          is_d;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q0[$];
  rsp_t        q1[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          starve = 0;
  bit          last_win_d = 1'b1;
  bit          g_i = 1'b0;
  bit          g_d = 1'b0;
  logic [31:0] exp_ird [2];
  logic [31:0] exp_drd [2];

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkv(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_port(int k);
    rsp_t e;
    bit   have = 1'b0;
    bit   ev_i, ev_d;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    ev_i = have && !e.is_d;
    ev_d = have && e.is_d;
    if (ev_i) exp_ird[k] = e.data;
    if (ev_d) exp_drd[k] = e.data;
    chk1($sformatf("i_rvalid%0d", k), i_rvalid[k], ev_i);
    chk1($sformatf("d_rvalid%0d", k), d_rvalid[k], ev_d);
    chkv($sformatf("i_rdata%0d", k), i_rdata[k], exp_ird[k]);
    chkv($sformatf("d_rdata%0d", k), d_rdata[k], exp_drd[k]);
  endtask

  // One clock cycle: check at the falling edge, advance the model, step past the rising edge.
  task automatic tick();
    bit          ei, ed;
    logic [3:0]  ea;
    @(negedge clk);
    if (i_req && d_req) ei = rr_mode ? last_win_d : (starve == SMAX);
    else                ei = i_req;
    ed = d_req && !ei;
    ea = ei ? i_addr : (ed ? d_addr : 4'd0);
    for (int k = 0; k < 2; k++) begin
      chk1($sformatf("i_gnt%0d", k), i_gnt[k], ei);
      chk1($sformatf("d_gnt%0d", k), d_gnt[k], ed);
      chk1($sformatf("mem_en%0d", k), mem_en[k], ei | ed);
      chkv($sformatf("mem_addr%0d", k), 32'(mem_addr[k]), 32'(ea));
      chk1($sformatf("fetch_stall%0d", k), fetch_stall[k], i_req && !ei);
      check_port(k);
    end
    if (ei || ed) begin
      q0.push_back('{due: cyc + 2, is_d: ed, data: mem[ea]});
      q1.push_back('{due: cyc + 3, is_d: ed, data: mem[ea]});
      last_win_d = ed;
    end
    if (!i_req || ei) starve = 0;
    else if (starve < SMAX) starve++;
    g_i = ei;
    g_d = ed;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    i_req = 1'b0;
    d_req = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk1($sformatf("rst_i_rvalid%0d", k), i_rvalid[k], 1'b0);
      chk1($sformatf("rst_d_rvalid%0d", k), d_rvalid[k], 1'b0);
      chkv($sformatf("rst_i_rdata%0d", k), i_rdata[k], 32'd0);
      chkv($sformatf("rst_d_rdata%0d", k), d_rdata[k], 32'd0);
      exp_ird[k] = '0;
      exp_drd[k] = '0;
    end
    q0.delete();
    q1.delete();
    starve = 0;
    last_win_d = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] fp_exp;
    for (int a = 0; a < 16; a++) mem[a] = $urandom;
    mem[2]  = 32'h1123_0000;
    mem[12] = 32'd10;
    do_reset();
    repeat (2) tick();

    // single fetch request
    i_req = 1'b1; i_addr = 4'd2;
    tick();
    i_req = 1'b0;
    repeat (4) tick();

    // fixed priority with starvation guard: D,D,D,I,D,D,D,I
    fp_exp = 8'b1000_1000;
    rr_mode = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 4'd3; d_addr = 4'd7;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk1($sformatf("fp_seq%0d", n), g_i, fp_exp[n]);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();

    // round-robin after reset starts with I
    do_reset();
    rr_mode = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 4'd5; d_addr = 4'd9;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk1($sformatf("rr_seq%0d", n), g_i, (n % 2) == 0);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();

    // back-to-back D then I grants
    d_req = 1'b1; d_addr = 4'd12;
    tick();
    d_req = 1'b0; i_req = 1'b1; i_addr = 4'd0;
    tick();
    i_req = 1'b0;
    repeat (4) tick();

    // mode switch with starve counter at 2
    rr_mode = 1'b0; i_req = 1'b1; i_addr = 4'd1;
    tick();
    d_req = 1'b1; d_addr = 4'd4;
    repeat (2) tick();
    rr_mode = 1'b1;
    tick();
    chk1("mode_switch_i_wins", g_i, 1'b1);
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();

    // reset with a grant in flight: the flushed request never returns
    i_req = 1'b1; i_addr = 4'd6;
    tick();
    do_reset();
    repeat (5) tick();

    // randomized traffic honouring hold-until-granted
    g_i = 1'b0; g_d = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        do_reset();
        g_i = 1'b0; g_d = 1'b0;
      end
      if (!i_req || g_i) begin
        i_req  = 1'($urandom_range(0, 1));
        i_addr = 4'($urandom_range(0, 15));
      end
      if (!d_req || g_d) begin
        d_req  = 1'($urandom_range(0, 1));
        d_addr = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
